dff_pipe: RTL and testbench
===========================

Name: dff_pipe

Overview:
- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, DEPTH-stage elastic register pipeline with a valid/ready handshake.
- Every stage is a bank of D flip-flops plus a valid bit.
- Stages advance independently, so bubbles collapse and back-pressure stalls only the stages that must hold.
- Sits between producer and consumer datapaths as a retiming/delay line; also provides occupancy and flush.

Parameters:
- WIDTH, 8, data bits per stage (>=1)
- DEPTH, 4, number of register stages (>=1)
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; not overridden)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset; clears all state when 0
- flush  input  1  synchronous clear of all stages
- in_valid  input  1  producer offers in_data
- in_ready  output  1  pipeline accepts a beat this cycle
- in_data  input  WIDTH  input beat
- out_valid  output  1  stage DEPTH-1 holds a beat
- out_ready  input  1  consumer accepts out_data
- out_data  output  WIDTH  data of stage DEPTH-1
- count  output  CNT_W  number of valid stages
- parity_err  output  1  parity mismatch on the output beat (see Optional Feature)

Behaviour:
- Stage state: v[i], d[i], for i = 0..DEPTH-1. Stage 0 is the input side.
- Reset (reset=0, asynchronous): all v[i]=0, all d[i]=0, count=0. Hence out_valid=0, out_data=0, parity_err=0. in_ready=1 as soon as reset releases, provided flush=0.
- Ready chain (combinational):
  - rdy[DEPTH] = out_ready
  - rdy[i] = !v[i] | rdy[i+1]
  - in_ready = rdy[0] & !flush
- Per clock edge, for each stage i:
  - If rdy[i]=1: v[i] <= upstream valid; d[i] <= upstream data, loaded only when upstream valid=1.
  - If rdy[i]=0: stage holds.
  - Upstream of stage 0 is in_valid & !flush with in_data; upstream of stage i is v[i-1], d[i-1].
- Transfers: an input transfer occurs when in_valid & in_ready; an output transfer when out_valid & out_ready.
- Latency: DEPTH cycles from input transfer to out_valid when unstalled. Throughput is 1 beat/cycle with out_ready held high.
- Ordering: beats are never reordered, duplicated or dropped, except by flush.
- Bubble collapse: a stalled output lets upstream empty stages fill. A full pipeline with out_ready=0 gives in_ready=0.
- Full with out_ready=1: a simultaneous input transfer and output transfer are both allowed; count is unchanged.
- count <= count + in_xfer - out_xfer. Range 0..DEPTH; never wraps.
- flush=1:
  - Next edge: all v[i] <= 0, count <= 0.
  - d[i] are not cleared.
  - in_ready=0 that cycle, so no beat is accepted.
  - An out_valid beat may still transfer that cycle if out_ready=1. Its data is presented normally; it is lost only if not taken.
- Reset mid-operation: immediate asynchronous clear regardless of handshake state; no partial beats survive.
- in_data is don't-care when in_valid=0. out_data is don't-care when out_valid=0, except after reset, when it is 0.
- DEPTH=1: single register with a combinational ready pass-through, same rules.

Optional Feature:
- Macro: DFF_PIPE_PARITY_EN
- Defined:
  - Each stage carries an extra bit p[i].
  - At input, p <= ^in_data.
  - parity_err = out_valid & (^out_data != p[DEPTH-1]).
  - p[i] resets to 0, is not cleared by flush, and moves with d[i].
  - A bench hook may force a stage bit to inject errors.
- Undefined: no parity storage; parity_err tied to 0.

Decomposition:
- Shared package/header (dff_pipe_pkg):
  - Default WIDTH and DEPTH constants
  - Count-width function (clog2)
  - Stage-index localparams
- Sub-module dff_pipe_stage:
  - One stage: v, d and optional p registers
  - Async active-low clear
  - load-enable = rdy[i]
- dff_pipe instantiates DEPTH stages in a generate loop, plus the ready chain, count logic and in/out muxing.

Test Plan:
- Reset/idle: hold reset=0 with in_valid=1, in_data=8'hAA, then release. Expect out_valid=0, out_data=0, count=0 throughout reset; in_ready=1 after release.
- Streaming (WIDTH=8, DEPTH=4, out_ready=1): send 8'h01..8'h08 on consecutive cycles. Expect the first beat 8'h01 at out_valid exactly 4 cycles after its transfer, then 8'h02..8'h08 back-to-back in order.
- Back-pressure: out_ready=0, push 8'h10..8'h13. Expect count=4, in_ready=0, and a fifth beat not accepted. Raise out_ready for 1 cycle while offering 8'h14: expect 8'h10 out, 8'h14 in, count stays 4.
- Bubble collapse: push 8'h20, idle 2 cycles, push 8'h21 with out_ready=0. Expect count=2, and after out_ready=1 the outputs 8'h20, 8'h21 on consecutive cycles.
- Flush and async reset: with count=3, pulse flush for 1 cycle with in_valid=1. Expect no acceptance and count=0 next cycle. Then mid-stream drive reset low off-edge: expect out_valid=0 and count=0 immediately.
- DFF_PIPE_PARITY_EN: stream 8'h5A, flip d[2] bit 0 via a force. Expect parity_err=1 only on that output beat; expect 0 when the macro is undefined.

Source files
------------

// File: rtl/dff_pipe_pkg.sv
// Shared constants and helpers for the dff_pipe elastic register pipeline.
// Optional parity tracking is enabled with DFF_PIPE_PARITY_EN.
package dff_pipe_pkg;

    localparam int DFLT_WIDTH = 8;
    localparam int DFLT_DEPTH = 4;

    localparam int STAGE_FIRST = 0;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One pipeline stage: valid bit, data register and optional parity bit.
// Parity storage exists only when DFF_PIPE_PARITY_EN is defined.
module dff_pipe_stage
    import dff_pipe_pkg::*;
#(
    parameter int WIDTH = DFLT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic             up_valid_i,
    input  logic [WIDTH-1:0] up_data_i,
    input  logic             up_par_i,
    output logic             v_o,
    output logic [WIDTH-1:0] d_o,
    output logic             p_o
);

    logic             v_q, v_d;
    logic [WIDTH-1:0] d_q, d_d;

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush_i) begin
            v_d = 1'b0;
        end else if (load_i) begin
            v_d = up_valid_i;
        end
        // data is never cleared by flush; only the valid bit drops
        if (load_i && up_valid_i) begin
            d_d = up_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign v_o = v_q;
    assign d_o = d_q;

`ifdef DFF_PIPE_PARITY_EN
    logic p_q, p_d;

    always_comb begin
        p_d = p_q;
        if (load_i && up_valid_i) begin
            p_d = up_par_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q <= 1'b0;
        end else begin
            p_q <= p_d;
        end
    end

    assign p_o = p_q;
`else
    logic unused_par;
    assign unused_par = up_par_i;
    assign p_o        = 1'b0;
`endif

endmodule

// File: rtl/dff_pipe.sv
// WIDTH-bit, DEPTH-stage elastic register pipeline with valid/ready flow.
// Define DFF_PIPE_PARITY_EN to carry a parity bit and flag output errors.
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int WIDTH = DFLT_WIDTH,
    parameter int DEPTH = DFLT_DEPTH,
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count,
    output logic             parity_err
);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] p;
    logic [DEPTH:0]   rdy;

    logic             head_v;
    logic             head_p;
    logic             in_xfer;
    logic             out_xfer;
    logic [CNT_W-1:0] count_q, count_d;

    // a stage can take a beat if it is empty or its successor moves
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = ~v[i] | rdy[i+1];
        end
    end

    assign head_v   = in_valid & ~flush;
    assign in_ready = rdy[0] & ~flush;

    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

`ifdef DFF_PIPE_PARITY_EN
    assign head_p     = ^in_data;
    assign parity_err = out_valid & ((^out_data) != p[DEPTH-1]);
`else
    logic unused_p;
    assign head_p     = 1'b0;
    assign parity_err = 1'b0;
    assign unused_p   = ^p;
`endif

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_v;
        logic [WIDTH-1:0] up_d;
        logic             up_p;

        if (i == STAGE_FIRST) begin : g_head
            assign up_v = head_v;
            assign up_d = in_data;
            assign up_p = head_p;
        end else begin : g_body
            assign up_v = v[i-1];
            assign up_d = d[i-1];
            assign up_p = p[i-1];
        end

        dff_pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk       (clk),
            .rst_n     (reset),
            .flush_i   (flush),
            .load_i    (rdy[i]),
            .up_valid_i(up_v),
            .up_data_i (up_d),
            .up_par_i  (up_p),
            .v_o       (v[i]),
            .d_o       (d[i]),
            .p_o       (p[i])
        );
    end

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_comb begin
        count_d = count_q + CNT_W'(in_xfer) - CNT_W'(out_xfer);
        if (flush) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_dff_pipe.sv
// Scoreboard bench for dff_pipe (WIDTH=8, DEPTH=4).
// Covers DFF_PIPE_PARITY_EN when the macro is defined for the build.
module tb_dff_pipe;
    import dff_pipe_pkg::*;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = cnt_width(D);

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] count;
    logic          parity_err;

    dff_pipe #(
        .WIDTH(W),
        .DEPTH(D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .parity_err(parity_err)
    );

    typedef struct {
        logic [W-1:0] data;
        logic         perr;
        int           in_cyc;
        int           lat;
        bit           b2b;
    } exp_t;

    exp_t sb[$];
    int   n_chk;
    int   n_fail;
    int   cyc;
    int   last_pop;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic iv, input logic [W-1:0] dat,
                        input logic ordy, input logic fl,
                        input int lat, input bit b2b);
        exp_t e;
        in_valid  = iv;
        in_data   = dat;
        out_ready = ordy;
        flush     = fl;
        #1;
        if (iv && in_ready && reset) begin
            e.data   = dat;
            e.perr   = 1'b0;
            e.in_cyc = cyc;
            e.lat    = lat;
            e.b2b    = b2b;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0);
            n++;
        end
        check(name, sb.size(), 0);
    endtask

    // monitor: checks every output transfer against the scoreboard
    initial begin
        exp_t e;
        last_pop = 0;
        forever begin
            @(negedge clk);
            #2;
            if (reset === 1'b1) begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_out: got %0h expected none",
                                 out_data);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", out_data, e.data);
                        check("parity_err", parity_err, e.perr);
                        if (e.lat != 0)
                            check("latency", cyc - e.in_cyc, e.lat);
                        if (e.b2b)
                            check("back_to_back", cyc - last_pop, 1);
                        last_pop = cyc;
                    end
                end else if (!out_valid) begin
                    check("parity_idle", parity_err, 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        n_chk     = 0;
        n_fail    = 0;
        cyc       = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hAA;
        out_ready = 1'b0;
        #2;
        reset = 1'b0;

        // reset held with a beat offered
        repeat (3) begin
            @(negedge clk);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_data", out_data, 0);
            check("rst_count", count, 0);
            check("rst_parity", parity_err, 0);
        end
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rel_in_ready", in_ready, 1);
        check("rel_out_valid", out_valid, 0);
        @(negedge clk);

        // streaming at full rate
        for (int k = 1; k <= 8; k++)
            step(1'b1, W'(k), 1'b1, 1'b0, D, k > 1);
        drain("stream_drain");
        check("stream_count", count, 0);

        // back-pressure fills, blocks, then swaps one beat
        for (int k = 0; k < 4; k++)
            step(1'b1, 8'h10 + W'(k), 1'b0, 1'b0, 0, 1'b0);
        check("bp_count_full", count, 4);
        step(1'b1, 8'h99, 1'b0, 1'b0, 0, 1'b0);
        check("bp_in_ready", in_ready, 0);
        check("bp_count_hold", count, 4);
        step(1'b1, 8'h14, 1'b1, 1'b0, 0, 1'b0);
        check("bp_count_swap", count, 4);
        drain("bp_drain");

        // bubble collapse behind a stalled output
        step(1'b1, 8'h20, 1'b0, 1'b0, 0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 8'h21, 1'b0, 1'b0, 0, 1'b1);
        check("bub_count", count, 2);
        step(1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0);
        check("bub_count_hold", count, 2);
        drain("bub_drain");

        // flush discards everything in flight
        step(1'b1, 8'h30, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 8'h31, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 8'h32, 1'b0, 1'b0, 0, 1'b0);
        check("fl_count_pre", count, 3);
        in_valid  = 1'b1;
        in_data   = 8'h33;
        out_ready = 1'b0;
        flush     = 1'b1;
        #1;
        check("fl_in_ready", in_ready, 0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        check("fl_count", count, 0);
        check("fl_out_valid", out_valid, 0);
        step(1'b1, 8'h40, 1'b1, 1'b0, D, 1'b0);
        step(1'b1, 8'h41, 1'b1, 1'b0, D, 1'b1);
        drain("fl_drain");

        // asynchronous reset mid-stream
        step(1'b1, 8'h50, 1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 8'h51, 1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 8'h52, 1'b1, 1'b0, 0, 1'b0);
        #3;
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("ar_out_valid", out_valid, 0);
        check("ar_count", count, 0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) step(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0);
        check("ar_count_after", count, 0);

        // parity on a single streamed beat
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        out_ready = 1'b1;
        flush     = 1'b0;
        #1;
        check("par_in_ready", in_ready, 1);
`ifdef DFF_PIPE_PARITY_EN
        e.data = 8'h5B;
        e.perr = 1'b1;
`else
        e.data = 8'h5A;
        e.perr = 1'b0;
`endif
        e.in_cyc = cyc;
        e.lat    = D;
        e.b2b    = 1'b0;
        if (in_ready) sb.push_back(e);
        @(negedge clk);
        step(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0);
`ifdef DFF_PIPE_PARITY_EN
        force dut.g_stage[2].u_stage.d_q = 8'h5B;
`endif
        step(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0);
`ifdef DFF_PIPE_PARITY_EN
        release dut.g_stage[2].u_stage.d_q;
`endif
        drain("par_drain");
        step(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0);
        check("par_clear", parity_err, 0);
        check("final_count", count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
